// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: the FSM state
// encodings and the default multiply/divide occupancies used by the MD datapath.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MD  = 1'b1
    } md_state_e;

    localparam int unsigned MUL_CYCLES_DEF = 32'd2;
    localparam int unsigned DIV_CYCLES_DEF = 32'd33;

endpackage

// File: rtl/pipe_ctrl_md_occ_cnt.sv
// md_occ_cnt: EX occupancy counter for mult/div.
// Supports clear, load, decrement and hold, and outputs a zero flag.
module md_occ_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Occupancy count: clear dominates load, load dominates decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall/bubble generator for the five-stage pipeline.
// Optional macro PIPE_CTRL_PERF_EN adds the perf_lu/perf_md/perf_bus cycle counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_rs_ren,
    input  logic        id_rt_ren,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_load,
    input  logic        ex_regwen,
    input  logic [4:0]  ex_wreg,
    input  logic        ex_mult,
    input  logic        ex_div,
    input  logic        ibus_stall,
    input  logic        dbus_stall,
    input  logic        exc_flush,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        refresh_id,
    output logic        refresh_ex,
    output logic        refresh_mem,
    output logic        refresh_wb,
    output logic        md_busy,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_lu,
    output logic [31:0] perf_md,
    output logic [31:0] perf_bus,
`endif
    output logic        md_done
);

    // The issue cycle is the first occupancy cycle and the done cycle the last one.
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 2);

    md_state_e        r_state;
    md_state_e        w_nxt_state;
    logic             w_cnt_zero;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_ld_val;
    logic             w_issue;
    logic             w_load_use;
    logic             w_rs_hit;
    logic             w_rt_hit;

    assign w_rs_hit   = id_rs_ren & (id_rs == ex_wreg);
    assign w_rt_hit   = id_rt_ren & (id_rt == ex_wreg);
    assign w_load_use = ex_load & ex_regwen & (ex_wreg != 5'd0) & (w_rs_hit | w_rt_hit);
    assign w_issue    = (r_state == ST_RUN) & (ex_mult | ex_div);
    assign w_ld_val   = ex_div ? DIV_LD : MUL_LD;
    assign md_busy    = (r_state == ST_MD);

    // Priority resolution of the single winning action into stall/bubble pattern
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        refresh_id  = 1'b0;
        refresh_ex  = 1'b0;
        refresh_mem = 1'b0;
        refresh_wb  = 1'b0;
        md_done     = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_nxt_state = r_state;
        if (exc_flush) begin
            refresh_id  = 1'b1;
            refresh_ex  = 1'b1;
            refresh_mem = 1'b1;
            w_nxt_state = ST_RUN;
        end else if (dbus_stall) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            stall_mem  = 1'b1;
            refresh_wb = 1'b1;
        end else if (r_state == ST_MD) begin
            if (w_cnt_zero) begin
                md_done     = 1'b1;
                w_nxt_state = ST_RUN;
            end else begin
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                stall_ex    = 1'b1;
                refresh_mem = 1'b1;
                w_cnt_dec   = 1'b1;
            end
        end else if (w_issue) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            stall_ex    = 1'b1;
            refresh_mem = 1'b1;
            w_cnt_load  = 1'b1;
            w_nxt_state = ST_MD;
        end else if (w_load_use) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            refresh_ex = 1'b1;
        end else if (ibus_stall) begin
            stall_if   = 1'b1;
            refresh_id = 1'b1;
        end else begin
            w_nxt_state = r_state;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    md_occ_cnt #(
        .CNT_W (CNT_W)
    ) u_md_occ_cnt (
        .clk        (clk),
        .rst_n      (resetn),
        .i_clr      (exc_flush),
        .i_load     (w_cnt_load),
        .i_load_val (w_ld_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic w_win_lu;
    logic w_win_md;
    logic w_win_bus;

    assign w_win_md  = ~exc_flush & ~dbus_stall & ((r_state == ST_MD) | w_issue);
    assign w_win_lu  = ~exc_flush & ~dbus_stall & (r_state == ST_RUN) & ~w_issue & w_load_use;
    assign w_win_bus = ~exc_flush & (dbus_stall |
                       ((r_state == ST_RUN) & ~w_issue & ~w_load_use & ibus_stall));

    // Wrapping counters of winning-action cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_lu  <= 32'd0;
            perf_md  <= 32'd0;
            perf_bus <= 32'd0;
        end else begin
            perf_lu  <= perf_lu  + {31'd0, w_win_lu};
            perf_md  <= perf_md  + {31'd0, w_win_md};
            perf_bus <= perf_bus + {31'd0, w_win_bus};
        end
    end
`endif

endmodule
